// File: rtl/dram_rand_tester_pkg.sv
// Shared types and constants for the DRAM pseudo-random write/verify tester.
// Holds the state encoding and the order in which generator outputs form a DRAM word.
package dram_rand_tester_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int RNG_WIDTH  = 64;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_SEED,
        ST_W_GEN0,
        ST_W_GEN1,
        ST_W_REQ,
        ST_R_SEED,
        ST_R_GEN0,
        ST_R_GEN1,
        ST_R_REQ,
        ST_R_WAIT,
        ST_DONE
    } state_e;

    // The first generator output fills the low half of the word, the second the high half.
    function automatic logic [DATA_WIDTH-1:0] assemble_word(
        input logic [RNG_WIDTH-1:0] second,
        input logic [RNG_WIDTH-1:0] first
    );
        return {second, first};
    endfunction

endpackage

// File: rtl/dram_rand_err_cnt.sv
// Saturating mismatch counter that also remembers the address of the first mismatch.
module dram_rand_err_cnt #(
    parameter int ADDR_WIDTH = 24,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_mismatch,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ERR_WIDTH-1:0]  o_count,
    output logic [ADDR_WIDTH-1:0] o_first_addr
);

    logic [ERR_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        count_d = count_q;
        first_d = first_q;
        if (i_clear) begin
            count_d = '0;
            first_d = '0;
        end else if (i_mismatch) begin
            if (count_q == '0) first_d = i_addr;
            if (count_q != '1) count_d = count_q + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so all flops sample pre-edge values.
        if (i_rst) begin
            count_q <= '0;
            first_q <= '0;
        end else begin
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign o_count      = count_q;
    assign o_first_addr = first_q;

endmodule

// File: rtl/dram_rand_tester.sv
// Writes NUM_WORDS xorshift128+ words to DRAM, re-seeds the generator, then reads
// them back and counts mismatches against the regenerated sequence.
module dram_rand_tester
    import dram_rand_tester_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int NUM_WORDS  = 1024,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_WIDTH-1:0]  o_err_count,
    output logic [ADDR_WIDTH-1:0] o_err_addr,
    output logic                  o_rng_rst,
    output logic                  o_rng_en,
    input  logic [RNG_WIDTH-1:0]  i_rng_data,
    output logic                  o_dram_wr_en,
    output logic                  o_dram_rd_en,
    output logic [ADDR_WIDTH-1:0] o_dram_addr,
    output logic [DATA_WIDTH-1:0] o_dram_wdata,
    input  logic                  i_dram_ready,
    input  logic                  i_dram_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_dram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  err_clear;
    logic                  mismatch;
    logic                  is_last;

    assign is_last = (addr_q == LAST_ADDR);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        err_clear = 1'b0;
        mismatch  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d   = ST_W_SEED;
                    addr_d    = '0;
                    err_clear = 1'b1;
                end
            end
            ST_W_SEED: begin
                state_d = ST_W_GEN0;
                addr_d  = '0;
            end
            ST_W_GEN0: begin
                buf_d   = assemble_word(buf_q[DATA_WIDTH-1:RNG_WIDTH], i_rng_data);
                state_d = ST_W_GEN1;
            end
            ST_W_GEN1: begin
                buf_d   = assemble_word(i_rng_data, buf_q[RNG_WIDTH-1:0]);
                state_d = ST_W_REQ;
            end
            ST_W_REQ: begin
                if (i_dram_ready) begin
                    if (is_last) begin
                        state_d = ST_R_SEED;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_W_GEN0;
                    end
                end
            end
            ST_R_SEED: begin
                state_d = ST_R_GEN0;
                addr_d  = '0;
            end
            ST_R_GEN0: begin
                buf_d   = assemble_word(buf_q[DATA_WIDTH-1:RNG_WIDTH], i_rng_data);
                state_d = ST_R_GEN1;
            end
            ST_R_GEN1: begin
                buf_d   = assemble_word(i_rng_data, buf_q[RNG_WIDTH-1:0]);
                state_d = ST_R_REQ;
            end
            ST_R_REQ: begin
                if (i_dram_ready) state_d = ST_R_WAIT;
            end
            ST_R_WAIT: begin
                // Only one read is outstanding, so valid here always belongs to addr_q.
                if (i_dram_rdata_valid) begin
                    mismatch = (i_dram_rdata != buf_q);
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_R_GEN0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    dram_rand_err_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ERR_WIDTH  (ERR_WIDTH)
    ) u_err_cnt (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (err_clear),
        .i_mismatch   (mismatch),
        .i_addr       (addr_q),
        .o_count      (o_err_count),
        .o_first_addr (o_err_addr)
    );

    assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done       = (state_q == ST_DONE);
    assign o_pass       = o_done && (o_err_count == '0);
    assign o_rng_rst    = (state_q == ST_W_SEED) || (state_q == ST_R_SEED);
    assign o_rng_en     = (state_q == ST_W_GEN0) || (state_q == ST_W_GEN1) ||
                          (state_q == ST_R_GEN0) || (state_q == ST_R_GEN1);
    assign o_dram_wr_en = (state_q == ST_W_REQ);
    assign o_dram_rd_en = (state_q == ST_R_REQ);
    assign o_dram_addr  = addr_q;
    assign o_dram_wdata = buf_q;

endmodule

// File: doc/dram_rand_tester.md
Name: dram_rand_tester

Overview:
- Consumer stage of the 64-bit xorshift128+ generator used by the DRAM test designs.
- Builds 128-bit pseudo-random words from pairs of generator outputs and writes NUM_WORDS of them to DRAM at consecutive word addresses.
- Then re-seeds the generator, reads the same range back, and compares each read against the regenerated sequence.
- Drives the generator's reset/enable, and sits between the generator and the DRAM controller's user command port.

Parameters:
- ADDR_WIDTH, 24: DRAM word-address width.
- NUM_WORDS, 1024: words written then verified; legal range 1..2^ADDR_WIDTH.
- ERR_WIDTH, 16: width of the mismatch counter.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE or DONE.
- o_busy  out  1  high in every state except IDLE and DONE.
- o_done  out  1  high while in DONE.
- o_pass  out  1  high in DONE when o_err_count==0.
- o_err_count  out  ERR_WIDTH  mismatches in the last run; saturating.
- o_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- o_rng_rst  out  1  generator reset (re-seed).
- o_rng_en  out  1  generator advance enable.
- i_rng_data  in  64  generator output for the current state.
- o_dram_wr_en  out  1  write request.
- o_dram_rd_en  out  1  read request.
- o_dram_addr  out  ADDR_WIDTH  command address.
- o_dram_wdata  out  128  write data.
- i_dram_ready  in  1  command accepted when (wr_en|rd_en)&&ready.
- i_dram_rdata_valid  in  1  read data valid; returns in order, arbitrary latency.
- i_dram_rdata  in  128  read data.

Behaviour:
- Reset: state=IDLE. All outputs 0, including addr, wdata, err_count, err_addr, o_rng_*.
- States: IDLE, W_SEED, W_GEN0, W_GEN1, W_REQ, R_SEED, R_GEN0, R_GEN1, R_REQ, R_WAIT, DONE.
- IDLE/DONE + i_start -> W_SEED: clear addr, err_count, err_addr. i_start is ignored in all other states.
- W_SEED / R_SEED:
  - o_rng_rst=1 for exactly one cycle, then go to *_GEN0 with addr=0.
  - The generator re-seeds at that edge, so i_rng_data is valid in *_GEN0.
- *_GEN0: latch i_rng_data into buffer[63:0]; o_rng_en=1.
- *_GEN1: latch i_rng_data into buffer[127:64]; o_rng_en=1. The word is {second, first}.
- o_rng_rst and o_rng_en are decodes of the registered state; they are never asserted together.
- W_REQ:
  - o_dram_wr_en=1, o_dram_wdata=buffer, o_dram_addr=addr.
  - Hold all three stable until i_dram_ready.
  - On accept: if addr==NUM_WORDS-1 go to R_SEED, else addr+1 and go to W_GEN0.
- R_REQ: o_dram_rd_en=1 with o_dram_addr=addr; hold until i_dram_ready; on accept go to R_WAIT. Exactly one read is outstanding at a time.
- R_WAIT on i_dram_rdata_valid:
  - Compare i_dram_rdata with buffer.
  - On mismatch: err_count+1, saturating at all-ones. Capture err_addr=addr only if err_count was 0.
  - Then: if addr==NUM_WORDS-1 go to DONE, else addr+1 and go to R_GEN0.
- i_dram_rdata_valid outside R_WAIT is ignored and does not touch the counters.
- Minimum cost per word: 3 cycles for a write; 3 cycles plus read latency for a read.
- NUM_WORDS=1: one write, then one read, then DONE.
- i_rst mid-run: back to IDLE with all outputs 0 after the edge. A command in flight is abandoned; the controller must tolerate this.
- DONE holds o_err_count and o_err_addr until the next start.

Decomposition:
- Shared package:
  - State encoding localparams.
  - DATA_WIDTH=128 and RNG_WIDTH=64 constants.
  - Word-assembly order ({second, first}).
- No sub-module required. The generator stays a separate sibling instance wired at the test top.
- An optional error-counter sub-module, dram_rand_err_cnt, may hold the saturate and first-address logic.

Test Plan:
- Golden path:
  - Stimulus: NUM_WORDS=4, ideal DRAM model (ready=1, read latency 5), generator SEED=0.
  - Response: 4 writes to addr 0..3, each wdata equal to the software xorshift128+ pair.
  - Then exactly 2 rng_rst pulses in the run, 4 reads, o_done=1, o_pass=1, o_err_count=0.
- Backpressure:
  - Stimulus: ready low for 7 cycles during W_REQ of addr 2.
  - Response: wr_en, addr=2 and wdata held constant for all 8 cycles; no generator advance during the hold.
- Single corruption:
  - Stimulus: model flips bit 0 of word 1 and bit 127 of word 3.
  - Response: o_err_count=2, o_err_addr=1, o_pass=0.
- Saturation:
  - Stimulus: ERR_WIDTH=2, NUM_WORDS=6, every read corrupted.
  - Response: o_err_count=3, o_err_addr=0.
- Spurious/early inputs:
  - Stimulus: rdata_valid pulses in W_REQ and R_REQ; i_start pulses while busy.
  - Response: counters unchanged, run unaffected, completes with o_pass=1.
- Reset mid-read:
  - Stimulus: i_rst in R_WAIT at addr 2.
  - Response: next cycle all outputs 0, state IDLE. A fresh i_start reruns the test and passes, with wdata identical to the first run.
